// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one i2c_controller engine among NREQ requesters.
// Optional per-transaction watchdog is compiled in when I2C_ARB_TIMEOUT_EN is defined.
module i2c_req_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned GW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [7*NREQ-1:0] REQ_ADDR,
  input  logic [8*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_RW,
  output logic [NREQ-1:0]   REQ_READY,
  output logic [NREQ-1:0]   RSP_VALID,
  output logic [7:0]        RSP_DATA,
  output logic              RSP_TIMEOUT,
  output logic [GW-1:0]     GRANT_ID,
  output logic              ARB_BUSY,
  output logic              CTRL_IDRDY,
  output logic [6:0]        CTRL_IADDR,
  output logic [7:0]        CTRL_IDATA,
  output logic              CTRL_I_RW,
  input  logic              CTRL_BUSY,
  input  logic [7:0]        CTRL_ODATA,
  input  logic              CTRL_ODRDY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, next_state;
  logic [GW-1:0]   last_grant;
  logic            gnt_found;
  logic [GW-1:0]   gnt_idx;
  logic [6:0]      sel_addr;
  logic [7:0]      sel_data;
  logic            sel_rw;
  logic [7:0]      rd_data;
  logic [7:0]      rsp_byte;
  logic            to_hit;
  logic [NREQ-1:0] gnt_onehot;
  logic [NREQ-1:0] rsp_onehot;

  assign gnt_onehot = NREQ'(1) << gnt_idx;
  assign rsp_onehot = NREQ'(1) << GRANT_ID;

  // Rotating priority: candidates are visited from last_grant+1 around to last_grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_rw    = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!gnt_found && REQ_VALID[k] && (k == (32'(last_grant) + i) % NREQ)) begin
          gnt_found = 1'b1;
          gnt_idx   = GW'(k);
          sel_addr  = REQ_ADDR[7*k +: 7];
          sel_data  = REQ_DATA[8*k +: 8];
          sel_rw    = REQ_RW[k];
        end
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_hit = ((state == S_ISSUE) || (state == S_WAIT)) &&
                  (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (!CTRL_BUSY && gnt_found) next_state = S_ISSUE;
      S_ISSUE: if (to_hit) next_state = S_RESP;
               else if (CTRL_BUSY) next_state = S_WAIT;
      S_WAIT:  if (to_hit || !CTRL_BUSY) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // A read byte arriving on the same cycle BUSY drops bypasses rd_data.
  always_comb begin
    rsp_byte = 8'h00;
    if (!to_hit && CTRL_I_RW) begin
      rsp_byte = ((state == S_WAIT) && CTRL_ODRDY) ? CTRL_ODATA : rd_data;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state       <= S_IDLE;
      last_grant  <= GW'(NREQ - 1);
      rd_data     <= '0;
      REQ_READY   <= '0;
      RSP_VALID   <= '0;
      RSP_DATA    <= '0;
      RSP_TIMEOUT <= 1'b0;
      GRANT_ID    <= '0;
      ARB_BUSY    <= 1'b0;
      CTRL_IDRDY  <= 1'b0;
      CTRL_IADDR  <= '0;
      CTRL_IDATA  <= '0;
      CTRL_I_RW   <= 1'b0;
    end else begin
      state       <= next_state;
      REQ_READY   <= '0;
      RSP_VALID   <= '0;
      RSP_TIMEOUT <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (next_state == S_ISSUE) begin
            REQ_READY  <= gnt_onehot;
            GRANT_ID   <= gnt_idx;
            CTRL_IADDR <= sel_addr;
            CTRL_IDATA <= sel_data;
            CTRL_I_RW  <= sel_rw;
            CTRL_IDRDY <= 1'b1;
            ARB_BUSY   <= 1'b1;
            rd_data    <= '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          if ((state == S_WAIT) && CTRL_ODRDY) rd_data <= CTRL_ODATA;
          if (next_state != S_ISSUE) CTRL_IDRDY <= 1'b0;
          if (next_state == S_RESP) begin
            RSP_VALID   <= rsp_onehot;
            RSP_TIMEOUT <= to_hit;
            RSP_DATA    <= rsp_byte;
          end
        end
        S_RESP: begin
          ARB_BUSY   <= 1'b0;
          last_grant <= GRANT_ID;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a response scoreboard and a scripted controller model.
module tb_i2c_req_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned TO   = 50;

  logic              CLK = 1'b0;
  logic              NRST;
  logic [NREQ-1:0]   REQ_VALID;
  logic [7*NREQ-1:0] REQ_ADDR;
  logic [8*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]   REQ_RW;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ-1:0]   RSP_VALID;
  logic [7:0]        RSP_DATA;
  logic              RSP_TIMEOUT;
  logic [1:0]        GRANT_ID;
  logic              ARB_BUSY;
  logic              CTRL_IDRDY;
  logic [6:0]        CTRL_IADDR;
  logic [7:0]        CTRL_IDATA;
  logic              CTRL_I_RW;
  logic              CTRL_BUSY;
  logic [7:0]        CTRL_ODATA;
  logic              CTRL_ODRDY;

  always #5 CLK = ~CLK;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .NRST(NRST),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_RW(REQ_RW),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .RSP_TIMEOUT(RSP_TIMEOUT), .GRANT_ID(GRANT_ID), .ARB_BUSY(ARB_BUSY),
    .CTRL_IDRDY(CTRL_IDRDY), .CTRL_IADDR(CTRL_IADDR), .CTRL_IDATA(CTRL_IDATA),
    .CTRL_I_RW(CTRL_I_RW), .CTRL_BUSY(CTRL_BUSY), .CTRL_ODATA(CTRL_ODATA),
    .CTRL_ODRDY(CTRL_ODRDY)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       to;
  } rsp_t;

  rsp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input logic t);
    rsp_t e;
    e.id = id; e.data = d; e.to = t;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
    REQ_ADDR[7*i +: 7] = a;
    REQ_DATA[8*i +: 8] = d;
    REQ_RW[i]          = rw;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_status_zero"},
        {REQ_READY, RSP_VALID, RSP_DATA, RSP_TIMEOUT, GRANT_ID, ARB_BUSY}, 64'd0);
    chk({tag, "_ctrl_zero"}, {CTRL_IDRDY, CTRL_IADDR, CTRL_IDATA, CTRL_I_RW}, 64'd0);
  endtask

  task automatic wait_ready(output int gid, output int cyc);
    gid = -1;
    cyc = 0;
    while (gid < 0 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      for (int b = 0; b < NREQ; b++) if (REQ_READY[b]) gid = b;
    end
    chk("ready_within_bound", 64'(gid >= 0), 64'd1);
  endtask

  // Controller model: BUSY rises 3 cycles after IDRDY, held for hold cycles.
  task automatic ctrl_run(input int hold, input logic odr, input logic [7:0] od);
    repeat (3) @(negedge CLK);
    chk("issue_idrdy_high", CTRL_IDRDY, 64'd1);
    CTRL_BUSY = 1'b1;
    @(negedge CLK);
    chk("wait_idrdy_low", CTRL_IDRDY, 64'd0);
    repeat (hold - 1) @(negedge CLK);
    chk("no_early_rsp", RSP_VALID, 64'd0);
    CTRL_BUSY  = 1'b0;
    CTRL_ODRDY = odr;
    CTRL_ODATA = od;
    @(negedge CLK);
    CTRL_ODRDY = 1'b0;
    CTRL_ODATA = 8'hEE;
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_rsp_valid"}, RSP_VALID, 64'(4'b0001 << e.id));
    chk({tag, "_rsp_data"}, RSP_DATA, 64'(e.data));
    chk({tag, "_rsp_timeout"}, RSP_TIMEOUT, 64'(e.to));
  endtask

  task automatic after_rsp(input string tag, input logic [7:0] held);
    @(negedge CLK);
    chk({tag, "_rsp_pulse_end"}, RSP_VALID, 64'd0);
    chk({tag, "_arb_idle"}, ARB_BUSY, 64'd0);
    chk({tag, "_rsp_data_hold"}, RSP_DATA, 64'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int gid, cyc, lastg, expg;
    logic no_ready;
    NRST = 1'b0; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; REQ_RW = '0;
    CTRL_BUSY = 1'b0; CTRL_ODATA = 8'hEE; CTRL_ODRDY = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    NRST = 1'b1;
    @(negedge CLK);

    // Single write from requester 2, fields changed after grant
    set_req(2, 7'h50, 8'hA5, 1'b0);
    REQ_VALID = 4'b0100;
    push_exp(2'd2, 8'h00, 1'b0);
    wait_ready(gid, cyc);
    chk("t1_grant_id", GRANT_ID, 64'd2);
    chk("t1_ready", REQ_READY, 64'h4);
    chk("t1_iaddr", CTRL_IADDR, 64'h50);
    chk("t1_idata", CTRL_IDATA, 64'hA5);
    chk("t1_irw", CTRL_I_RW, 64'd0);
    chk("t1_arb_busy", ARB_BUSY, 64'd1);
    REQ_VALID = '0;
    set_req(2, 7'h7F, 8'h00, 1'b1);
    ctrl_run(200, 1'b0, 8'h00);
    check_rsp("t1");
    chk("t1_iaddr_held", CTRL_IADDR, 64'h50);
    after_rsp("t1", 8'h00);

    // Read from requester 0 with ODRDY on the BUSY-falling cycle
    set_req(0, 7'h1D, 8'h00, 1'b1);
    REQ_VALID = 4'b0001;
    push_exp(2'd0, 8'h3C, 1'b0);
    wait_ready(gid, cyc);
    chk("t2_grant_id", gid, 64'd0);
    chk("t2_iaddr", CTRL_IADDR, 64'h1D);
    chk("t2_irw", CTRL_I_RW, 64'd1);
    REQ_VALID = '0;
    ctrl_run(20, 1'b1, 8'h3C);
    check_rsp("t2");
    after_rsp("t2", 8'h3C);

    // BUSY high in idle blocks grant; read without ODRDY returns cleared byte
    set_req(1, 7'h22, 8'h00, 1'b1);
    CTRL_BUSY = 1'b1;
    REQ_VALID = 4'b0010;
    no_ready = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (REQ_READY != '0) no_ready = 1'b1;
    end
    chk("t4_no_grant_while_busy", no_ready, 64'd0);
    CTRL_BUSY = 1'b0;
    push_exp(2'd1, 8'h00, 1'b0);
    wait_ready(gid, cyc);
    chk("t4_grant_next_edge", cyc, 64'd1);
    chk("t4_grant_id", gid, 64'd1);
    REQ_VALID = '0;
    ctrl_run(10, 1'b0, 8'h00);
    check_rsp("t4");
    after_rsp("t4", 8'h00);

    // Round robin from reset with all four requesters held
    NRST = 1'b0;
    @(negedge CLK);
    NRST = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(7'h10 + i), 8'(8'h20 + i), 1'b0);
    REQ_VALID = 4'hF;
    lastg = 3;
    for (int t = 0; t < 5; t++) begin
      expg = (lastg + 1) % NREQ;
      push_exp(2'(expg), 8'h00, 1'b0);
      wait_ready(gid, cyc);
      chk("rr_order", gid, 64'(expg));
      chk("rr_ready_onehot", REQ_READY, 64'(4'b0001 << expg));
      if (t > 0) chk("rr_b2b_spacing", cyc, 64'd1);
      chk("rr_idata", CTRL_IDATA, 64'(8'h20 + expg));
      ctrl_run(5, 1'b0, 8'h00);
      check_rsp("rr");
      after_rsp("rr", 8'h00);
      lastg = expg;
    end
    REQ_VALID = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: controller never raises BUSY
    set_req(3, 7'h33, 8'h44, 1'b0);
    REQ_VALID = 4'b1000;
    push_exp(2'd3, 8'h00, 1'b1);
    wait_ready(gid, cyc);
    chk("to_grant_id", gid, 64'd3);
    REQ_VALID = '0;
    repeat (TO - 1) @(negedge CLK);
    chk("to_idrdy_before_limit", CTRL_IDRDY, 64'd1);
    chk("to_no_early_rsp", RSP_VALID, 64'd0);
    @(negedge CLK);
    check_rsp("to");
    chk("to_idrdy_dropped", CTRL_IDRDY, 64'd0);
    after_rsp("to", 8'h00);
`endif

    // Reset in the middle of S_WAIT
    set_req(1, 7'h2A, 8'h5A, 1'b0);
    REQ_VALID = 4'b0010;
    wait_ready(gid, cyc);
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);
    CTRL_BUSY = 1'b1;
    @(negedge CLK);
    chk("rst_in_wait_busy", ARB_BUSY, 64'd1);
    #2;
    NRST = 1'b0;
    CTRL_BUSY = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    @(negedge CLK);
    chk_zero("reset_held");
    NRST = 1'b1;
    set_req(0, 7'h0A, 8'h0B, 1'b0);
    set_req(3, 7'h3A, 8'h3B, 1'b0);
    REQ_VALID = 4'b1001;
    push_exp(2'd0, 8'h00, 1'b0);
    wait_ready(gid, cyc);
    chk("post_reset_req0_wins", gid, 64'd0);
    chk("post_reset_iaddr", CTRL_IADDR, 64'h0A);
    REQ_VALID = 4'b1000;
    ctrl_run(5, 1'b0, 8'h00);
    check_rsp("post_reset");
    REQ_VALID = '0;
    after_rsp("post_reset", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
